uart_frame_tx: RTL and testbench
================================

Name: uart_frame_tx

Overview:
- Serialises a multi-byte message word onto a single UART line, least-significant byte first; each byte is framed 8N1 (start, data, stop).
- Sits between a message-assembly stage, which presents the full packet plus a valid strobe, and the physical TX pin.
- The receive-side deserialiser, uart_rx, can be connected directly to out_bit.

Parameters:
- FULL_DATA_SIZE, 40: message width in bits; must be an integer multiple of BYTE_SIZE.
- BYTE_SIZE, 8: data bits per UART character.
- CLKS_PER_BIT, 4: CLK cycles per serial bit; must be ≥1.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  asynchronous, active-low reset.
- full_data  input  FULL_DATA_SIZE  message to send; byte k = full_data[k*BYTE_SIZE +: BYTE_SIZE].
- in_valid  input  1  start request; sampled only while idle.
- out_bit  output  1  serial line; idles high.
- busy  output  1  high from the accept cycle until the last stop bit ends.
- done  output  1  one-cycle pulse when the final stop bit completes.

Behaviour:
- Reset (RST=0, asynchronous): out_bit=1, busy=0, done=0; FSM goes to IDLE; bit/byte/baud counters cleared. Reset mid-frame aborts the frame immediately and the line returns high.
- NBYTES = FULL_DATA_SIZE/BYTE_SIZE (5 by default).
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - out_bit=1.
  - On a rising edge with in_valid=1: latch full_data into a shift register, set busy=1, go to START.
- START:
  - out_bit=0 for CLKS_PER_BIT cycles.
  - Then go to DATA with bit index 0.
- DATA:
  - out_bit = current byte bit[index], LSB first; each bit lasts CLKS_PER_BIT cycles.
  - After bit BYTE_SIZE-1, go to STOP.
- STOP:
  - out_bit=1 for CLKS_PER_BIT cycles.
  - If bytes remain: advance to the next byte and go straight to START (no inter-byte idle).
  - Otherwise: go to IDLE, busy=0, done=1 for one cycle.
- out_bit is registered. The start bit appears on the first edge after the accept edge.
- Frame length: NBYTES*(BYTE_SIZE+2)*CLKS_PER_BIT cycles (200 with defaults).
- in_valid while busy is ignored; there is no queueing. An in_valid held for several cycles therefore starts exactly one frame.
- in_valid on the same edge as done/return to IDLE is ignored; it is accepted on the following cycle if still high.
- Changes to full_data after acceptance do not affect the frame in flight.

Optional Feature:
- Macro UART_FRAME_TX_PARITY_EN.
- When defined: an even-parity bit (XOR of the byte's data bits) is inserted between the last data bit and the stop bit. It occupies a PARITY state lasting CLKS_PER_BIT cycles. Frame length becomes NBYTES*(BYTE_SIZE+3)*CLKS_PER_BIT.
- When undefined: no parity state exists; the frame is pure 8N1.

Decomposition:
- Shared package uart_pkg holds:
  - the FSM state typedef (IDLE/START/DATA/STOP/PARITY);
  - localparam helpers for NBYTES;
  - counter widths, computed with $clog2 of BYTE_SIZE, NBYTES and CLKS_PER_BIT.
- Sub-module uart_baud_gen: a counter that produces a one-cycle bit_tick every CLKS_PER_BIT cycles, restarted on frame accept. It is reusable by uart_rx.

Test Plan:
All scenarios use CLKS_PER_BIT=1 unless noted.
- Reset: hold RST=0 for 5 cycles, in_valid=1 → out_bit=1, busy=0, done=0 throughout. Release → still idle until in_valid is sampled.
- Basic frame: full_data=40'h00_03_aa_bb_47, in_valid high for 2 cycles → out_bit sequence:
  - 0,11100010,1 (byte 0x47)
  - 0,11011101,1 (0xbb)
  - 0,01010101,1 (0xaa)
  - 0,11000000,1 (0x03)
  - 0,00000000,1 (0x00)
  - Expect 50 bit times, one frame only, busy for 50 cycles, done pulse once, uart_rx decodes 47 bb aa 03 00.
- Busy lockout: pulse in_valid with new data 10 cycles into a frame → ignored; the original bytes complete unchanged.
- Baud: CLKS_PER_BIT=4, full_data=40'hff_00_ff_00_a5 → each bit is stable for exactly 4 cycles; total 200 cycles.
- Reset mid-frame: assert RST at bit 17 → out_bit=1 immediately, busy=0. A new in_valid after release sends a complete fresh frame.
- Back-to-back: keep in_valid=1 continuously → the second frame starts one cycle after done; each frame is framed correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: types and sizing helpers shared by the UART transmit/receive blocks.
//   uart_state_e : framing FSM states (PARITY is used only when parity is built in)
//   nbytes()     : characters per message word
//   cnt_w()      : counter width for a modulus, never narrower than one bit
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    PARITY
  } uart_state_e;

  localparam int unsigned DEF_FULL_DATA_SIZE = 40;
  localparam int unsigned DEF_BYTE_SIZE      = 8;
  localparam int unsigned DEF_CLKS_PER_BIT   = 4;

  function automatic int unsigned nbytes(input int unsigned full_size,
                                         input int unsigned byte_size);
    return full_size / byte_size;
  endfunction

  function automatic int unsigned cnt_w(input int unsigned modulus);
    return (modulus > 1) ? $clog2(modulus) : 1;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period timer. Emits a one-cycle bit_tick on the last
// cycle of every CLKS_PER_BIT-cycle bit period while enabled.
//   clk      : system clock, rising edge
//   rst_n    : asynchronous active-low reset
//   restart  : clear the period counter (frame accept)
//   en       : count while high
//   bit_tick : high during the final cycle of a bit period
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  input  logic en,
  output logic bit_tick
);

  localparam int unsigned CNT_W = cnt_w(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign bit_tick = en && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (restart) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = bit_tick ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_frame_tx.sv
// uart_frame_tx: serialises a FULL_DATA_SIZE-bit message onto one UART line,
// least-significant character first, each character framed 8N1.
//   CLK       : system clock, rising edge
//   RST       : asynchronous active-low reset
//   full_data : message; character k = full_data[k*BYTE_SIZE +: BYTE_SIZE]
//   in_valid  : start request, sampled only while idle
//   out_bit   : registered serial line, idles high
//   busy      : high from the accept cycle until the final stop bit period ends
//   done      : one-cycle pulse when the final stop bit period completes
// Build option: define UART_FRAME_TX_PARITY_EN to insert an even-parity bit
// between the last data bit and the stop bit of every character.
module uart_frame_tx
  import uart_pkg::*;
#(
  parameter int unsigned FULL_DATA_SIZE = DEF_FULL_DATA_SIZE,
  parameter int unsigned BYTE_SIZE      = DEF_BYTE_SIZE,
  parameter int unsigned CLKS_PER_BIT   = DEF_CLKS_PER_BIT
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [FULL_DATA_SIZE-1:0] full_data,
  input  logic                      in_valid,
  output logic                      out_bit,
  output logic                      busy,
  output logic                      done
);

  localparam int unsigned NBYTES = nbytes(FULL_DATA_SIZE, BYTE_SIZE);
  localparam int unsigned BIT_W  = cnt_w(BYTE_SIZE);
  localparam int unsigned BYTE_W = cnt_w(NBYTES);
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(BYTE_SIZE - 1);
  localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(NBYTES - 1);

  uart_state_e               state_q, state_d;
  logic [BIT_W-1:0]          bit_idx_q, bit_idx_d;
  logic [BYTE_W-1:0]         byte_idx_q, byte_idx_d;
  logic [FULL_DATA_SIZE-1:0] shreg_q, shreg_d;
  logic                      out_bit_q, out_bit_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      accept;
  logic                      bit_tick;
  logic [BYTE_SIZE-1:0]      cur_byte;

  // The character in flight always sits in the low bits; the register is
  // shifted down one character at each inter-character STOP->START step.
  assign cur_byte = shreg_q[BYTE_SIZE-1:0];

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (CLK),
    .rst_n   (RST),
    .restart (accept),
    .en      (state_q != IDLE),
    .bit_tick(bit_tick)
  );

  always_comb begin
    state_d    = state_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    shreg_d    = shreg_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    out_bit_d  = 1'b1;
    accept     = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          accept     = 1'b1;
          shreg_d    = full_data;
          bit_idx_d  = '0;
          byte_idx_d = '0;
          busy_d     = 1'b1;
          state_d    = START;
        end
      end
      START: begin
        out_bit_d = 1'b0;
        if (bit_tick) begin
          bit_idx_d = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        out_bit_d = cur_byte[bit_idx_q];
        if (bit_tick) begin
          if (bit_idx_q == LAST_BIT) begin
`ifdef UART_FRAME_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
`ifdef UART_FRAME_TX_PARITY_EN
      PARITY: begin
        out_bit_d = ^cur_byte;
        if (bit_tick) begin
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        out_bit_d = 1'b1;
        if (bit_tick) begin
          if (byte_idx_q == LAST_BYTE) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            byte_idx_d = byte_idx_q + 1'b1;
            shreg_d    = shreg_q >> BYTE_SIZE;
            state_d    = START;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= IDLE;
      bit_idx_q  <= '0;
      byte_idx_q <= '0;
      shreg_q    <= '0;
      out_bit_q  <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      shreg_q    <= shreg_d;
      out_bit_q  <= out_bit_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign out_bit = out_bit_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_uart_frame_tx.sv
// tb_uart_frame_tx: directed bench for uart_frame_tx (default 8N1 build).
// Two instances: u_dut1 at one clock per bit, u_dut4 at four clocks per bit.
module tb_uart_frame_tx;

  logic        CLK = 1'b0;
  logic        RST;
  logic [39:0] d1_data, d4_data;
  logic        d1_valid, d4_valid;
  logic        o1, b1, dn1, o4, b4, dn4;
  logic        sel4;
  logic        mon_out, mon_busy, mon_done;

  int n_checks = 0;
  int n_errors = 0;

  logic cap_bits [0:511];
  logic cap_busy [0:511];
  logic cap_done [0:511];

  always #5 CLK = ~CLK;

  uart_frame_tx #(
    .FULL_DATA_SIZE(40),
    .BYTE_SIZE     (8),
    .CLKS_PER_BIT  (1)
  ) u_dut1 (
    .CLK      (CLK),
    .RST      (RST),
    .full_data(d1_data),
    .in_valid (d1_valid),
    .out_bit  (o1),
    .busy     (b1),
    .done     (dn1)
  );

  uart_frame_tx #(
    .FULL_DATA_SIZE(40),
    .BYTE_SIZE     (8),
    .CLKS_PER_BIT  (4)
  ) u_dut4 (
    .CLK      (CLK),
    .RST      (RST),
    .full_data(d4_data),
    .in_valid (d4_valid),
    .out_bit  (o4),
    .busy     (b4),
    .done     (dn4)
  );

  assign mon_out  = sel4 ? o4  : o1;
  assign mon_busy = sel4 ? b4  : b1;
  assign mon_done = sel4 ? dn4 : dn1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Sample index i is taken at the falling edge after rising edge i
  // (edge 0 being the first edge of the capture).
  task automatic capture(input int n, input int drop_at, input int pulse_at,
                         input logic [39:0] alt);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      cap_bits[i] = mon_out;
      cap_busy[i] = mon_busy;
      cap_done[i] = mon_done;
      if (i == drop_at) begin
        d1_valid = 1'b0;
        d4_valid = 1'b0;
      end
      if (i == pulse_at) begin
        d1_data  = alt;
        d1_valid = 1'b1;
      end
      if (pulse_at >= 0 && i == pulse_at + 1) d1_valid = 1'b0;
    end
  endtask

  function automatic int sum_busy(input int from, input int to);
    int s = 0;
    for (int i = from; i <= to; i++) s += int'(cap_busy[i]);
    return s;
  endfunction

  function automatic int sum_done(input int from, input int to);
    int s = 0;
    for (int i = from; i <= to; i++) s += int'(cap_done[i]);
    return s;
  endfunction

  function automatic int first_done(input int from, input int to);
    for (int i = from; i <= to; i++) if (cap_done[i] === 1'b1) return i;
    return -1;
  endfunction

  function automatic int zeros_in(input int from, input int to);
    int s = 0;
    for (int i = from; i <= to; i++) if (cap_bits[i] !== 1'b1) s++;
    return s;
  endfunction

  // Ten line bits of one character, first transmitted bit in the MSB.
  function automatic logic [9:0] char_at(input int base, input int stride);
    logic [9:0] v;
    for (int j = 0; j < 10; j++) v[9-j] = cap_bits[base + j*stride];
    return v;
  endfunction

  function automatic logic [39:0] decode(input int base, input int stride);
    logic [39:0] d;
    logic [9:0]  ch;
    for (int b = 0; b < 5; b++) begin
      ch = char_at(base + b*10*stride, stride);
      for (int j = 0; j < 8; j++) d[b*8 + j] = ch[8-j];
    end
    return d;
  endfunction

  function automatic int frame_errs(input int base, input int stride);
    int e = 0;
    logic [9:0] ch;
    for (int b = 0; b < 5; b++) begin
      ch = char_at(base + b*10*stride, stride);
      if (ch[9] !== 1'b0 || ch[0] !== 1'b1) e++;
    end
    return e;
  endfunction

  function automatic logic exp_bit(input logic [39:0] data, input int k);
    int p = k % 10;
    if (p == 0) return 1'b0;
    if (p == 9) return 1'b1;
    return data[(k/10)*8 + p - 1];
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "bench time limit reached");
  end

  initial begin
    int bad;
    RST      = 1'b0;
    sel4     = 1'b0;
    d1_data  = 40'h0;
    d4_data  = 40'h0;
    d1_valid = 1'b1;
    d4_valid = 1'b1;

    // Reset held with in_valid high: both instances stay idle.
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      if (o1 !== 1'b1 || b1 !== 1'b0 || dn1 !== 1'b0) bad++;
      if (o4 !== 1'b1 || b4 !== 1'b0 || dn4 !== 1'b0) bad++;
    end
    check("rst_hold", bad, 0);
    d1_valid = 1'b0;
    d4_valid = 1'b0;
    RST = 1'b1;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      if (o1 !== 1'b1 || b1 !== 1'b0 || dn1 !== 1'b0) bad++;
    end
    check("rel_idle", bad, 0);

    // Basic frame, in_valid high across two edges.
    d1_data  = 40'h00_03_aa_bb_47;
    d1_valid = 1'b1;
    capture(60, 1, -1, 40'h0);
    check("acc_out",  cap_bits[0], 1'b1);
    check("acc_busy", cap_busy[0], 1'b1);
    check("chr0", char_at(1, 1),  10'b0_11100010_1);
    check("chr1", char_at(11, 1), 10'b0_11011101_1);
    check("chr2", char_at(21, 1), 10'b0_01010101_1);
    check("chr3", char_at(31, 1), 10'b0_11000000_1);
    check("chr4", char_at(41, 1), 10'b0_00000000_1);
    check("basic_dec",  decode(1, 1), 40'h00_03_aa_bb_47);
    check("basic_busy", sum_busy(0, 59), 50);
    check("basic_ndone", sum_done(0, 59), 1);
    check("basic_done_at", first_done(0, 59), 50);
    check("basic_tail_idle", zeros_in(50, 59), 0);

    // Busy lockout: new request and new data ten cycles in are ignored.
    d1_data  = 40'h11_22_33_44_55;
    d1_valid = 1'b1;
    capture(70, 0, 10, 40'hde_ad_be_ef_99);
    check("lock_dec",   decode(1, 1), 40'h11_22_33_44_55);
    check("lock_ferr",  frame_errs(1, 1), 0);
    check("lock_busy",  sum_busy(0, 69), 50);
    check("lock_ndone", sum_done(0, 69), 1);
    check("lock_tail",  zeros_in(51, 69), 0);

    // Four clocks per bit.
    sel4     = 1'b1;
    d4_data  = 40'hff_00_ff_00_a5;
    d4_valid = 1'b1;
    capture(210, 0, -1, 40'h0);
    bad = 0;
    for (int k = 0; k < 50; k++)
      for (int j = 0; j < 4; j++)
        if (cap_bits[1 + 4*k + j] !== exp_bit(40'hff_00_ff_00_a5, k)) bad++;
    check("baud_stable", bad, 0);
    check("baud_chr0", char_at(1, 4), 10'b0_10100101_1);
    check("baud_dec",  decode(3, 4), 40'hff_00_ff_00_a5);
    check("baud_busy", sum_busy(0, 209), 200);
    check("baud_done_at", first_done(0, 209), 200);
    check("baud_ndone", sum_done(0, 209), 1);
    sel4 = 1'b0;

    // Reset in the middle of bit 17.
    d1_data  = 40'h0;
    d1_valid = 1'b1;
    capture(18, 0, -1, 40'h0);
    @(negedge CLK);
    check("mid_bit17", {o1, b1}, 2'b01);
    RST = 1'b0;
    #1;
    check("mid_rst_out",  o1, 1'b1);
    check("mid_rst_busy", {b1, dn1}, 2'b00);
    @(negedge CLK);
    RST      = 1'b1;
    d1_data  = 40'h12_34_56_78_9a;
    d1_valid = 1'b1;
    capture(60, 0, -1, 40'h0);
    check("fresh_dec",  decode(1, 1), 40'h12_34_56_78_9a);
    check("fresh_busy", sum_busy(0, 59), 50);
    check("fresh_done_at", first_done(0, 59), 50);

    // Back-to-back with in_valid held high.
    d1_data  = 40'h5a_5a_0f_0f_f0;
    d1_valid = 1'b1;
    capture(160, 101, -1, 40'h0);
    check("b2b_gap_busy", {cap_busy[49], cap_busy[50], cap_busy[51]}, 3'b101);
    check("b2b_gap_line", {cap_bits[50], cap_bits[51], cap_bits[52]}, 3'b110);
    check("b2b_dec1", decode(1, 1),  40'h5a_5a_0f_0f_f0);
    check("b2b_dec2", decode(52, 1), 40'h5a_5a_0f_0f_f0);
    check("b2b_ferr", frame_errs(1, 1) + frame_errs(52, 1), 0);
    check("b2b_done2", first_done(51, 159), 101);
    check("b2b_ndone", sum_done(0, 159), 2);
    check("b2b_busy",  sum_busy(0, 159), 100);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
